// File: rtl/peak_finder_if.sv
// rtl/peak_finder_if.sv - sample/threshold inputs and peak event outputs of peak_finder
`timescale 1ns/1ps
interface peak_finder_if #(
    parameter int DATA_W  = 16,
    parameter int TS_W    = 32,
    parameter int WIDTH_W = 8
);
    logic signed [DATA_W-1:0]  input_data;
    logic signed [DATA_W-1:0]  threshold;
    logic                      peak_valid;
    logic signed [DATA_W-1:0]  peak_amp;
    logic        [TS_W-1:0]    peak_time;
    logic        [WIDTH_W-1:0] peak_width;
    logic                      peak_long;
    logic                      peak_pileup;

    modport master (
        output input_data, threshold,
        input  peak_valid, peak_amp, peak_time, peak_width, peak_long, peak_pileup
    );

    modport slave (
        input  input_data, threshold,
        output peak_valid, peak_amp, peak_time, peak_width, peak_long, peak_pileup
    );
endinterface

// File: rtl/peak_finder.sv
// rtl/peak_finder.sv - threshold pulse detector reporting peak amplitude, time and width
// Optional pile-up detection is compiled in with PEAK_FINDER_PILEUP_EN.
`timescale 1ns/1ps
module peak_finder #(
    parameter int DATA_W    = 16,
    parameter int TS_W      = 32,
    parameter int WIDTH_W   = 8,
    parameter int MIN_WIDTH = 2,
    parameter int MAX_WIDTH = 64,
    parameter int DEAD_TIME = 4
) (
    input logic          clk,
    input logic          reset,
    peak_finder_if.slave pf
);
    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_DEAD} state_t;

    localparam int DCNT_W = (DEAD_TIME > 2) ? $clog2(DEAD_TIME) : 1;
    localparam logic [DCNT_W-1:0]  DEAD_LAST = DCNT_W'((DEAD_TIME > 0) ? DEAD_TIME - 1 : 0);
    localparam logic [WIDTH_W-1:0] W_MAX     = WIDTH_W'(MAX_WIDTH);
    localparam logic [WIDTH_W-1:0] W_MIN     = WIDTH_W'(MIN_WIDTH);

    state_t                    r_state, w_next;
    logic signed [DATA_W-1:0]  r_s, r_max;
    logic        [TS_W-1:0]    r_ts, r_ts_s, r_tmax;
    logic        [WIDTH_W-1:0] r_width;
    logic        [DCNT_W-1:0]  r_dead_cnt;

    logic                      r_peak_valid, r_peak_long;
    logic signed [DATA_W-1:0]  r_peak_amp;
    logic        [TS_W-1:0]    r_peak_time;
    logic        [WIDTH_W-1:0] r_peak_width;

    logic                      w_above, w_new_max, w_dead_done;
    logic        [WIDTH_W-1:0] w_width_inc;
    logic                      w_start, w_grow, w_cut, w_emit;
    logic signed [DATA_W-1:0]  w_emit_amp;
    logic        [TS_W-1:0]    w_emit_time;
    logic        [WIDTH_W-1:0] w_emit_width;

    assign w_above     = r_s > pf.threshold;
    assign w_new_max   = r_s > r_max;
    assign w_width_inc = r_width + 1'b1;
    assign w_dead_done = r_dead_cnt >= DEAD_LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_above) w_next = S_PULSE;
            S_PULSE: if (!w_above || w_width_inc == W_MAX) w_next = S_DEAD;
            S_DEAD:  if (w_dead_done && !w_above) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // A MAX_WIDTH cut reports on the cutting sample itself, so fold it into the result.
    always_comb begin
        w_start      = (r_state == S_IDLE) && w_above;
        w_grow       = (r_state == S_PULSE) && w_above;
        w_cut        = w_grow && (w_width_inc == W_MAX);
        w_emit       = w_cut || ((r_state == S_PULSE) && !w_above && (r_width >= W_MIN));
        w_emit_amp   = (w_cut && w_new_max) ? r_s    : r_max;
        w_emit_time  = (w_cut && w_new_max) ? r_ts_s : r_tmax;
        w_emit_width = w_cut ? w_width_inc : r_width;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ts       <= '0;
            r_ts_s     <= '0;
            r_s        <= '0;
            r_max      <= '0;
            r_tmax     <= '0;
            r_width    <= '0;
            r_dead_cnt <= '0;
        end else begin
            r_ts   <= r_ts + 1'b1;
            r_ts_s <= r_ts;
            r_s    <= pf.input_data;
            if (w_start) begin
                r_max   <= r_s;
                r_tmax  <= r_ts_s;
                r_width <= {{(WIDTH_W-1){1'b0}}, 1'b1};
            end else if (w_grow) begin
                r_width <= w_width_inc;
                if (w_new_max) begin
                    r_max  <= r_s;
                    r_tmax <= r_ts_s;
                end
            end
            if (r_state != S_DEAD)  r_dead_cnt <= '0;
            else if (!w_dead_done)  r_dead_cnt <= r_dead_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_peak_valid <= 1'b0;
            r_peak_amp   <= '0;
            r_peak_time  <= '0;
            r_peak_width <= '0;
            r_peak_long  <= 1'b0;
        end else begin
            r_peak_valid <= w_emit;
            if (w_emit) begin
                r_peak_amp   <= w_emit_amp;
                r_peak_time  <= w_emit_time;
                r_peak_width <= w_emit_width;
                r_peak_long  <= w_cut;
            end
        end
    end

    assign pf.peak_valid = r_peak_valid;
    assign pf.peak_amp   = r_peak_amp;
    assign pf.peak_time  = r_peak_time;
    assign pf.peak_width = r_peak_width;
    assign pf.peak_long  = r_peak_long;

`ifdef PEAK_FINDER_PILEUP_EN
    logic signed [DATA_W-1:0] r_prev;
    logic                     r_falling, r_pileup, r_peak_pileup;
    logic                     w_rise;

    // A rise only counts as pile-up once the pulse has already started falling.
    assign w_rise = w_grow && r_falling && (r_s > r_prev);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev        <= '0;
            r_falling     <= 1'b0;
            r_pileup      <= 1'b0;
            r_peak_pileup <= 1'b0;
        end else begin
            if (w_start) begin
                r_prev    <= r_s;
                r_falling <= 1'b0;
                r_pileup  <= 1'b0;
            end else if (w_grow) begin
                r_prev <= r_s;
                if (r_s < r_prev) r_falling <= 1'b1;
                if (w_rise)       r_pileup  <= 1'b1;
            end
            if (w_emit) r_peak_pileup <= r_pileup | w_rise;
        end
    end

    assign pf.peak_pileup = r_peak_pileup;
`else
    assign pf.peak_pileup = 1'b0;
`endif
endmodule

// File: tb/tb_peak_finder.sv
// tb/tb_peak_finder.sv - directed self-checking bench for peak_finder
`timescale 1ns/1ps
module tb_peak_finder;
    localparam int DATA_W  = 16;
    localparam int TS_W    = 8;
    localparam int WIDTH_W = 8;
    localparam int TS_MOD  = 1 << TS_W;
`ifdef PEAK_FINDER_PILEUP_EN
    localparam int PU_EXP = 1;
`else
    localparam int PU_EXP = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    peak_finder_if #(.DATA_W(DATA_W), .TS_W(TS_W), .WIDTH_W(WIDTH_W)) pf ();

    peak_finder #(
        .DATA_W(DATA_W), .TS_W(TS_W), .WIDTH_W(WIDTH_W),
        .MIN_WIDTH(2), .MAX_WIDTH(64), .DEAD_TIME(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pf    (pf)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int last_cyc;

    typedef struct {
        int amp; int tm; int wd; int lg; int pu; int at;
    } ev_t;
    ev_t ev_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!reset && pf.peak_valid)
            ev_q.push_back('{int'(pf.peak_amp), int'(pf.peak_time), int'(pf.peak_width),
                             int'(pf.peak_long), int'(pf.peak_pileup), cyc});
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int v);
        @(negedge clk);
        pf.input_data = DATA_W'(v);
        last_cyc = cyc;
    endtask

    task automatic idle(input int v, input int n);
        repeat (n) drive(v);
    endtask

    task automatic expect_event(input string tag, input int amp, input int tm, input int wd,
                                input int lg, input int pu, input int at);
        check({tag, ".count"}, ev_q.size(), 1);
        if (ev_q.size() > 0) begin
            ev_t e;
            e = ev_q[0];
            check({tag, ".amp"},    e.amp, amp);
            check({tag, ".time"},   e.tm,  tm);
            check({tag, ".width"},  e.wd,  wd);
            check({tag, ".long"},   e.lg,  lg);
            check({tag, ".pileup"}, e.pu,  pu);
            check({tag, ".cycle"},  e.at,  at);
        end
        ev_q.delete();
    endtask

    initial begin
        int t, k, guard;
        reset = 1'b1;
        pf.threshold  = DATA_W'(100);
        pf.input_data = '0;
        repeat (3) @(negedge clk);
        check("rst.valid", int'(pf.peak_valid), 0);
        check("rst.amp",   int'(pf.peak_amp),   0);
        check("rst.time",  int'(pf.peak_time),  0);
        check("rst.width", int'(pf.peak_width), 0);
        check("rst.long",  int'(pf.peak_long),  0);
        reset = 1'b0;

        // single pulse
        drive(0); drive(0); drive(150);
        drive(300); t = last_cyc;
        drive(250);
        drive(50);  k = last_cyc;
        idle(0, 10);
        expect_event("single", 300, t % TS_MOD, 3, 0, 0, k + 2);

        // fall then rise inside one pulse
        drive(200);
        drive(400); t = last_cyc;
        drive(300); drive(350);
        drive(50);  k = last_cyc;
        idle(0, 10);
        expect_event("pileup", 400, t % TS_MOD, 4, 0, PU_EXP, k + 2);

        // asynchronous reset in the middle of a pulse
        drive(150); drive(200);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst.valid",  int'(pf.peak_valid),  0);
        check("arst.amp",    int'(pf.peak_amp),    0);
        check("arst.time",   int'(pf.peak_time),   0);
        check("arst.width",  int'(pf.peak_width),  0);
        check("arst.pileup", int'(pf.peak_pileup), 0);
        pf.input_data = '0;
        @(negedge clk);
        reset = 1'b0;
        idle(0, 10);
        check("arst.noevent", ev_q.size(), 0);
        ev_q.delete();
        drive(120);
        drive(130); t = last_cyc;
        drive(0);   k = last_cyc;
        idle(0, 10);
        expect_event("after_rst", 130, t % TS_MOD, 2, 0, 0, k + 2);

        // one-sample glitch rejected, then back to IDLE after the dead time
        drive(200);
        idle(0, 5);
        check("glitch.noevent", ev_q.size(), 0);
        ev_q.delete();
        drive(180);
        drive(190); t = last_cyc;
        drive(0);   k = last_cyc;
        idle(0, 10);
        expect_event("post_glitch", 190, t % TS_MOD, 2, 0, 0, k + 2);

        // long plateau cut at MAX_WIDTH, no re-trigger while still high
        t = 0; k = 0;
        for (int i = 0; i < 70; i++) begin
            drive(500);
            if (i == 0)  t = last_cyc;
            if (i == 63) k = last_cyc;
        end
        idle(0, 12);
        expect_event("long", 500, t % TS_MOD, 64, 1, 0, k + 2);

        // negative threshold, second pulse inside dead time
        idle(-100, 3);
        pf.threshold = DATA_W'(-50);
        idle(-100, 3);
        drive(-40);
        drive(-10); t = last_cyc;
        drive(-60); k = last_cyc;
        drive(-60); drive(-20); drive(-20);
        idle(-100, 10);
        expect_event("negative", -10, t % TS_MOD, 2, 0, 0, k + 2);

        // timestamp wrap
        guard = 0;
        while (((last_cyc + 1) % TS_MOD) != 253 && guard < 600) begin
            drive(-100);
            guard++;
        end
        check("wrap.align", (last_cyc + 1) % TS_MOD, 253);
        drive(-30); drive(-20); drive(-15); drive(-8);
        drive(-5);  t = last_cyc;
        drive(-45);
        drive(-100); k = last_cyc;
        idle(-100, 10);
        expect_event("wrap", -5, t % TS_MOD, 6, 0, 0, k + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
